// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port, IR handshake to decode,
// and branch redirect from the control unit.
interface instr_fetch_unit_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
);
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] ir_out;
  logic          ir_valid;
  logic          ir_ready;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus1;
  logic          br_valid;
  logic [AW-1:0] br_target;

  modport master (
    output mem_en, mem_addr, ir_out, ir_valid, pc_out, pc_plus1,
    input  mem_dout, ir_ready, br_valid, br_target
  );

  modport slave (
    input  mem_en, mem_addr, ir_out, ir_valid, pc_out, pc_plus1,
    output mem_dout, ir_ready, br_valid, br_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle-latency memory read, IR with valid/ready.
// Optional FETCH_PERF_CNT_EN adds a saturating handshake counter (fetch_count).
module instr_fetch_unit #(
  parameter int unsigned   AW       = 10,
  parameter int unsigned   DW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  run,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]           fetch_count,
`endif
  instr_fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {IDLE, REQ, CAPT, HOLD} state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] pc_q, pc_q_n;
  logic [DW-1:0] ir, ir_n;
  logic          consume;

  assign consume = (state == HOLD) && bus.ir_ready;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      pc_q  <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pc_q  <= pc_q_n;
      ir    <= ir_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pc_q_n  = pc_q;
    ir_n    = ir;
    unique case (state)
      IDLE: if (run) state_n = REQ;
      REQ:  state_n = CAPT;
      CAPT: begin
        ir_n    = bus.mem_dout;
        pc_q_n  = pc;
        state_n = HOLD;
      end
      HOLD: if (bus.ir_ready) begin
        pc_n    = pc + AW'(1);
        state_n = run ? REQ : IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Redirect overrides the above; a capture in flight is dropped, not written.
    if (bus.br_valid) begin
      pc_n    = bus.br_target;
      pc_q_n  = pc_q;
      ir_n    = ir;
      state_n = (state == IDLE && !run) ? IDLE : REQ;
    end
  end

  assign bus.mem_en   = (state == REQ);
  assign bus.mem_addr = pc;
  assign bus.ir_out   = ir;
  assign bus.ir_valid = (state == HOLD);
  assign bus.pc_out   = pc_q;
  assign bus.pc_plus1 = pc_q + AW'(1);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      fetch_count <= '0;
    else if (consume && fetch_count != '1)
      fetch_count <= fetch_count + 16'd1;
  end
`else
  logic unused_consume;
  assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed timing scenarios plus a
// randomized run checked against a program-flow scoreboard.
module tb_instr_fetch_unit;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif
  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] mem [1024];

  instr_fetch_unit_if #(.AW(AW), .DW(DW)) bus ();

  instr_fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(10'h000)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .run         (run),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
`endif
    .bus         (bus.master)
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory, one cycle read latency
  always @(posedge CLK) if (bus.mem_en) bus.mem_dout <= mem[bus.mem_addr];

  task automatic do_reset(input logic r_run, input logic r_rdy);
    reset = 1'b0; run = r_run; bus.ir_ready = r_rdy;
    bus.br_valid = 1'b0; bus.br_target = '0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b1; bus.ir_ready = 1'b1; bus.br_valid = 1'b0; bus.br_target = '0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr, bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1} !==
        {1'b0, 10'h000, 1'b0, 16'h0000, 10'h000, 10'h001}) begin
      n_fail++;
      $display("FAIL reset_values: got en=%b addr=%h v=%b ir=%h pc=%h p1=%h, expected 0 0 0 0000 000 001",
               bus.mem_en, bus.mem_addr, bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.mem_en, bus.ir_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_held: got en=%b v=%b, expected 0 0", bus.mem_en, bus.ir_valid);
    end
  endtask

  task automatic test_basic;
    mem[0] = 16'h1D0F; mem[1] = 16'h00F3;
    do_reset(1'b1, 1'b1);
    @(negedge CLK);
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'h000}) begin
      n_fail++; $display("FAIL basic_req: got en=%b addr=%h, expected 1 000", bus.mem_en, bus.mem_addr);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.mem_en, bus.ir_valid} !== 2'b00) begin
      n_fail++; $display("FAIL basic_capt: got en=%b v=%b, expected 0 0", bus.mem_en, bus.ir_valid);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1} !== {1'b1, 16'h1D0F, 10'h000, 10'h001}) begin
      n_fail++; $display("FAIL basic_first: got v=%b ir=%h pc=%h p1=%h, expected 1 1d0f 000 001",
                         bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr, bus.ir_valid} !== {1'b1, 10'h001, 1'b0}) begin
      n_fail++; $display("FAIL basic_req2: got en=%b addr=%h v=%b, expected 1 001 0",
                         bus.mem_en, bus.mem_addr, bus.ir_valid);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1} !== {1'b1, 16'h00F3, 10'h001, 10'h002}) begin
      n_fail++; $display("FAIL basic_second: got v=%b ir=%h pc=%h p1=%h, expected 1 00f3 001 002",
                         bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1);
    end
  endtask

  task automatic test_stall;
    do_reset(1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CLK);
      n_cmp++;
      if ({bus.ir_valid, bus.ir_out, bus.pc_out, bus.mem_en} !== {1'b1, 16'h1D0F, 10'h000, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b ir=%h pc=%h en=%b, expected 1 1d0f 000 0",
                           k, bus.ir_valid, bus.ir_out, bus.pc_out, bus.mem_en);
      end
    end
    bus.ir_ready = 1'b1;
    @(negedge CLK);
    bus.ir_ready = 1'b0;
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'h001}) begin
      n_fail++; $display("FAIL stall_release: got en=%b addr=%h, expected 1 001", bus.mem_en, bus.mem_addr);
    end
  endtask

  task automatic test_branch_capt;
    mem[10'h155] = 16'hA5C3;
    do_reset(1'b1, 1'b1);
    repeat (2) @(negedge CLK);
    bus.br_valid = 1'b1; bus.br_target = 10'h155;
    @(negedge CLK);
    bus.br_valid = 1'b0;
    n_cmp++;
    if ({bus.ir_valid, bus.mem_en, bus.mem_addr, bus.ir_out, bus.pc_out} !==
        {1'b0, 1'b1, 10'h155, 16'h0000, 10'h000}) begin
      n_fail++; $display("FAIL branch_discard: got v=%b en=%b addr=%h ir=%h pc=%h, expected 0 1 155 0000 000",
                         bus.ir_valid, bus.mem_en, bus.mem_addr, bus.ir_out, bus.pc_out);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({bus.ir_valid, bus.ir_out, bus.pc_out} !== {1'b1, 16'hA5C3, 10'h155}) begin
      n_fail++; $display("FAIL branch_fetch: got v=%b ir=%h pc=%h, expected 1 a5c3 155",
                         bus.ir_valid, bus.ir_out, bus.pc_out);
    end
  endtask

  task automatic test_wrap;
    mem[10'h3FF] = 16'h7E81;
    do_reset(1'b1, 1'b0);
    @(negedge CLK);
    bus.br_valid = 1'b1; bus.br_target = 10'h3FF;
    @(negedge CLK);
    bus.br_valid = 1'b0;
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'h3FF}) begin
      n_fail++; $display("FAIL wrap_req: got en=%b addr=%h, expected 1 3ff", bus.mem_en, bus.mem_addr);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1} !== {1'b1, 16'h7E81, 10'h3FF, 10'h000}) begin
      n_fail++; $display("FAIL wrap_present: got v=%b ir=%h pc=%h p1=%h, expected 1 7e81 3ff 000",
                         bus.ir_valid, bus.ir_out, bus.pc_out, bus.pc_plus1);
    end
    bus.ir_ready = 1'b1;
    @(negedge CLK);
    bus.ir_ready = 1'b0;
    n_cmp++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'h000}) begin
      n_fail++; $display("FAIL wrap_next: got en=%b addr=%h, expected 1 000", bus.mem_en, bus.mem_addr);
    end
  endtask

  task automatic test_async_reset;
    do_reset(1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({bus.ir_valid, bus.ir_out} !== {1'b1, 16'h1D0F}) begin
      n_fail++; $display("FAIL async_pre: got v=%b ir=%h, expected 1 1d0f", bus.ir_valid, bus.ir_out);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ir_valid, bus.ir_out, bus.pc_out, bus.mem_en, bus.mem_addr} !==
        {1'b0, 16'h0000, 10'h000, 1'b0, 10'h000}) begin
      n_fail++; $display("FAIL async_reset: got v=%b ir=%h pc=%h en=%b addr=%h, expected 0 0000 000 0 000",
                         bus.ir_valid, bus.ir_out, bus.pc_out, bus.mem_en, bus.mem_addr);
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_count;
    do_reset(1'b1, 1'b1);
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL perf_init: got %0d expected 0", fetch_count);
    end
    repeat (12) @(negedge CLK);
    run = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (fetch_count !== 16'd4) begin
      n_fail++; $display("FAIL perf_four: got %0d expected 4", fetch_count);
    end
    bus.br_valid = 1'b1; bus.br_target = 10'h005;
    @(negedge CLK);
    bus.br_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (fetch_count !== 16'd4) begin
      n_fail++; $display("FAIL perf_branch: got %0d expected 4", fetch_count);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d expected 0", fetch_count);
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask
`endif

  // Scoreboard: next presented/requested address is the latest branch target,
  // otherwise the successor of the last consumed instruction.
  task automatic test_random;
    int hs;
    logic [AW-1:0] exp_next;
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    do_reset(1'b1, 1'b0);
    exp_next = '0;
    hs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      run           = ($urandom_range(0, 7) != 0);
      bus.ir_ready  = ($urandom_range(0, 2) != 0);
      bus.br_valid  = ($urandom_range(0, 15) == 0);
      bus.br_target = AW'($urandom);
      if (bus.mem_en) begin
        n_cmp++;
        if (bus.mem_addr !== exp_next) begin
          n_fail++; $display("FAIL rand_addr@%0d: got %h expected %h", c, bus.mem_addr, exp_next);
        end
      end
      if (bus.ir_valid && bus.ir_ready) begin
        n_cmp++;
        if ({bus.pc_out, bus.ir_out} !== {exp_next, mem[exp_next]}) begin
          n_fail++; $display("FAIL rand_instr@%0d: got pc=%h ir=%h expected pc=%h ir=%h",
                             c, bus.pc_out, bus.ir_out, exp_next, mem[exp_next]);
        end
        exp_next = exp_next + AW'(1);
        hs++;
      end
      if (bus.br_valid) exp_next = bus.br_target;
    end
    bus.br_valid = 1'b0;
    n_cmp++;
    if (hs < 50) begin
      n_fail++; $display("FAIL rand_progress: got %0d handshakes expected at least 50", hs);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    bus.ir_ready = 1'b0; bus.br_valid = 1'b0; bus.br_target = '0;
    test_reset;
    test_basic;
    test_stall;
    test_branch_capt;
    test_wrap;
    test_async_reset;
`ifdef FETCH_PERF_CNT_EN
    test_perf_count;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
